// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM streamers (read side today, write side later).
package sram_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} stream_state_e;
  localparam int SRAM_RD_LATENCY  = 1;
  localparam int STREAM_BUF_DEPTH = 2;
endpackage

// File: rtl/stream_skid_fifo.sv
// 2-entry FIFO that absorbs SRAM read data; head drives the stream directly.
module stream_skid_fifo #(
  parameter int WIDTH = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             head_vld,
  output logic [1:0]       count
);
  logic [1:0][WIDTH-1:0] mem;
  logic                  rd_ptr, wr_ptr;
  logic                  do_push, do_pop;

  assign do_pop   = pop && (count != 2'd0);
  // Full + pop: the freed head slot is exactly where wr_ptr points.
  assign do_push  = push && ((count != 2'd2) || do_pop);
  assign head     = mem[rd_ptr];
  assign head_vld = (count != 2'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mem    <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end
endmodule

// File: rtl/sram_read_streamer.sv
// Burst reader: issues SRAM reads under a 2-credit limit and streams returned words.
module sram_read_streamer
  import sram_pkg::*;
#(
  parameter  int DEPTH      = 64,
  parameter  int SRAM_WIDTH = 64,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_sram_active_low_en,
  output logic                  o_sram_read_write_en,
  output logic [SRAM_WIDTH-1:0] o_sram_write_bitmask,
  output logic [SRAM_WIDTH-1:0] o_sram_data_in,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  input  logic [SRAM_WIDTH-1:0] i_sram_data_out,
  output logic [SRAM_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready
);
  stream_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   issue_rem_q, deliver_rem_q;
  logic                  inflight_q, done_zero_q;
  logic [1:0]            buf_cnt;
  logic [2:0]            outstanding;
  logic                  pop, credit, issue, last_pop, accept;

  assign pop         = o_valid && i_ready;
  assign outstanding = 3'(buf_cnt) + 3'(inflight_q);
  // A pop this cycle frees a slot in time for the read issued now.
  assign credit      = (outstanding < 3'(STREAM_BUF_DEPTH)) ||
                       (pop && (outstanding == 3'(STREAM_BUF_DEPTH)));
  assign issue       = (state_q == ISSUE) && credit && (issue_rem_q != '0);
  assign last_pop    = (state_q == DRAIN) && pop && (deliver_rem_q == 1);
  assign accept      = i_start && ((state_q == IDLE) || last_pop);

  assign o_done               = last_pop || done_zero_q;
  assign o_busy               = (state_q != IDLE) && !last_pop;
  assign o_sram_active_low_en = !issue;
  assign o_sram_addr          = addr_q;
  assign o_sram_read_write_en = 1'b0;
  assign o_sram_write_bitmask = '0;
  assign o_sram_data_in       = '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ISSUE:   if (issue && (issue_rem_q == 1)) state_d = DRAIN;
      DRAIN:   if (last_pop) state_d = IDLE;
      default: state_d = state_q;
    endcase
    if (accept && (i_len != '0)) state_d = ISSUE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      issue_rem_q   <= '0;
      deliver_rem_q <= '0;
      inflight_q    <= 1'b0;
      done_zero_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      inflight_q  <= issue;
      done_zero_q <= accept && (i_len == '0);
      if (accept) begin
        addr_q        <= i_base_addr;
        issue_rem_q   <= i_len;
        deliver_rem_q <= i_len;
      end else begin
        if (issue) begin
          addr_q      <= (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
          issue_rem_q <= issue_rem_q - 1'b1;
        end
        if (pop) deliver_rem_q <= deliver_rem_q - 1'b1;
      end
    end
  end

  stream_skid_fifo #(.WIDTH(SRAM_WIDTH)) u_buf (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .push      (inflight_q),
    .push_data (i_sram_data_out),
    .pop       (pop),
    .head      (o_data),
    .head_vld  (o_valid),
    .count     (buf_cnt)
  );
endmodule

// File: tb/tb_sram_read_streamer.sv
// Scoreboard bench: SRAM model preloaded with 0x1000+k, bursts checked in order.
module tb_sram_read_streamer;
  localparam int DEPTH = 64;
  localparam int W     = 64;
  localparam int AW    = 6;

  logic          i_clk = 1'b0;
  logic          i_rst, i_start, i_ready;
  logic [AW-1:0] i_base_addr;
  logic [AW:0]   i_len;
  logic          o_busy, o_done, o_sram_active_low_en, o_sram_read_write_en, o_valid;
  logic [W-1:0]  o_sram_write_bitmask, o_sram_data_in, o_data, sram_q;
  logic [AW-1:0] o_sram_addr;
  logic [W-1:0]  mem [DEPTH];

  sram_read_streamer #(.DEPTH(DEPTH), .SRAM_WIDTH(W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_len(i_len), .o_busy(o_busy), .o_done(o_done),
    .o_sram_active_low_en(o_sram_active_low_en), .o_sram_read_write_en(o_sram_read_write_en),
    .o_sram_write_bitmask(o_sram_write_bitmask), .o_sram_data_in(o_sram_data_in),
    .o_sram_addr(o_sram_addr), .i_sram_data_out(sram_q), .o_data(o_data),
    .o_valid(o_valid), .i_ready(i_ready)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) if (!o_sram_active_low_en) sram_q <= mem[o_sram_addr];

  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [63:0] exp_data[$];
  int          exp_addr[$];
  int          pops = 0, issues_out = 0, done_cnt = 0;
  bit          bp_mode = 1'b0, prev_stall = 1'b0;
  logic [63:0] prev_data;
  bit [5:0]    bp_pat = 6'b101001;  // bit i = ready in cycle i: 1,0,0,1,0,1
  int          bpi = 0;

  // Downstream ready driver.
  always @(posedge i_clk) begin
    #1;
    if (bp_mode) begin
      i_ready = bp_pat[bpi % 6];
      bpi++;
    end else i_ready = 1'b1;
  end

  // Monitor: address/data order, credit limit, stall stability, done/busy relation.
  always @(negedge i_clk) begin
    if (i_rst) begin
      prev_stall = 1'b0;
      issues_out = 0;
    end else begin
      chk("sram_we", {o_sram_read_write_en, |o_sram_write_bitmask, |o_sram_data_in}, 0);
      if (prev_stall) begin
        chk("stall_valid", o_valid, 1);
        chk("stall_data", o_data, prev_data);
      end
      if (!o_sram_active_low_en) begin
        chk("issue_expected", exp_addr.size() != 0, 1);
        if (exp_addr.size() != 0) chk("sram_addr", o_sram_addr, exp_addr.pop_front());
        chk("credit", (issues_out - int'(o_valid && i_ready)) < 2, 1);
        issues_out++;
      end
      if (o_valid && i_ready) begin
        chk("word_expected", exp_data.size() != 0, 1);
        if (exp_data.size() != 0) chk("o_data", o_data, exp_data.pop_front());
        issues_out--;
        pops++;
        if (o_done) chk("done_on_last", exp_data.size(), 0);
      end
      if (o_done) begin
        done_cnt++;
        chk("busy_in_done", o_busy, 0);
      end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
    end
  end

  task automatic push_exp(input int base, input int len);
    for (int k = 0; k < len; k++) begin
      exp_addr.push_back((base + k) % DEPTH);
      exp_data.push_back(64'h1000 + 64'((base + k) % DEPTH));
    end
  endtask

  task automatic start(input int base, input int len);
    @(posedge i_clk); #1;
    i_start     = 1'b1;
    i_base_addr = AW'(base);
    i_len       = (AW+1)'(len);
    push_exp(base, len);
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int max);
    int n = 0;
    while (done_cnt == d0 && n < max) begin
      @(posedge i_clk);
      n++;
    end
    chk("done_seen", done_cnt != d0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int d0, lat, n, p0;
    i_rst = 1'b1; i_start = 1'b0; i_base_addr = '0; i_len = '0; i_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) mem[k] = 64'h1000 + 64'(k);
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_en", o_sram_active_low_en, 1);
    chk("rst_addr", o_sram_addr, 0);
    chk("rst_data", o_data, 0);
    i_rst = 1'b0;

    // Basic burst with first-valid latency
    d0 = done_cnt;
    start(4, 4);
    chk("busy_after_start", o_busy, 1);
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      if (o_valid) break;
      lat++;
    end
    chk("first_valid_lat", lat, 3);
    wait_done(d0, 50);
    chk("basic_drained", exp_data.size(), 0);

    // Address wrap
    d0 = done_cnt;
    start(62, 4);
    wait_done(d0, 50);
    chk("wrap_drained", exp_data.size() + exp_addr.size(), 0);

    // Backpressure
    bp_mode = 1'b1;
    d0 = done_cnt;
    start(0, 6);
    wait_done(d0, 100);
    bp_mode = 1'b0;
    chk("bp_drained", exp_data.size(), 0);

    // Zero-length burst
    d0 = done_cnt;
    start(5, 0);
    @(negedge i_clk);
    chk("len0_done", o_done, 1);
    chk("len0_busy", o_busy, 0);
    @(negedge i_clk);
    chk("len0_done_pulse", o_done, 0);
    chk("len0_valid", o_valid, 0);
    chk("len0_done_cnt", done_cnt, d0 + 1);

    // Reset mid-burst after two delivered words
    p0 = pops;
    start(0, 8);
    n = 0;
    while (pops < p0 + 2 && n < 50) begin
      @(posedge i_clk);
      n++;
    end
    chk("mid_two_pops", pops >= p0 + 2, 1);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    d0 = done_cnt;
    exp_data.delete();
    exp_addr.delete();
    @(negedge i_clk);
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_done", o_done, 0);
    repeat (3) @(negedge i_clk);
    chk("mid_rst_no_done", done_cnt, d0);
    start(10, 1);
    wait_done(d0, 50);
    chk("after_rst_drained", exp_data.size(), 0);

    // Back-to-back bursts: second start in the done cycle
    d0 = done_cnt;
    start(20, 3);
    n = 0;
    while (n < 50) begin
      @(negedge i_clk);
      if (o_done) break;
      n++;
    end
    chk("b2b_first_done", o_done, 1);
    #1;
    i_start = 1'b1; i_base_addr = AW'(40); i_len = (AW+1)'(3);
    push_exp(40, 3);
    @(posedge i_clk); #1;
    i_start = 1'b0;
    chk("b2b_busy", o_busy, 1);
    wait_done(d0 + 1, 50);
    chk("b2b_drained", exp_data.size(), 0);
    chk("b2b_done_cnt", done_cnt, d0 + 2);

    repeat (3) @(posedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
